// File: rtl/event_packet_decoder.sv
// -----------------------------------------------------------------------------
// event_packet_decoder
//
// Receive side of the pixel-arbiter event stream. Each granted event word
// {row, col, pol} is captured into a one-word staging register, its polarity
// is checked (01 = ON, 10 = OFF are legal; 00 and 11 are not), and legal
// events are pushed into a small FIFO that is presented downstream on a
// valid/ready interface. A small FSM tracks arbitration groups delimited by
// grp_release_i and reports the number of legal events in each closed group.
//
// Optional feature (macro EVT_TIMESTAMP_EN): a free-running TS_W-bit cycle
// counter is sampled when a word is captured, stored with the FIFO entry and
// presented on ts_o together with the head event. Without the macro there is
// no counter, no timestamp storage and no ts_o port.
//
// Ports
//   clk_i          clock
//   reset_ni       asynchronous active-low reset
//   evt_valid_i    event word present this cycle
//   data_i         {row, col, pol} event word
//   grp_release_i  arbiter group-release pulse
//   evt_valid_o    FIFO head valid
//   evt_ready_i    sink accepts head
//   row_o/col_o    head row / column address
//   pol_o          head polarity, 1 = ON, 0 = OFF
//   grp_busy_o     group in progress
//   grp_done_o     one-cycle pulse when a group closes
//   grp_len_o      legal events in the last closed group (held)
//   err_cnt_o      illegal-polarity words seen (saturating)
//   drop_cnt_o     legal events lost to a full FIFO (saturating)
//   overflow_o     sticky: any drop since reset
//   ts_o           head timestamp (EVT_TIMESTAMP_EN only)
// -----------------------------------------------------------------------------
module event_packet_decoder #(
  parameter  int ROWS       = 16,
  parameter  int COLS       = 16,
  parameter  int POLARITY   = 2,
  parameter  int FIFO_DEPTH = 8,
  parameter  int CNT_W      = 8,
  parameter  int TS_W       = 16,
  localparam int ROW_W      = $clog2(ROWS),
  localparam int COL_W      = $clog2(COLS),
  localparam int WIDTH      = ROW_W + COL_W + POLARITY
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             evt_valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             grp_release_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             pol_o,
  output logic             grp_busy_o,
  output logic             grp_done_o,
  output logic [CNT_W-1:0] grp_len_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic             overflow_o
`ifdef EVT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]  ts_o
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0]    CNT_MAX = '1;
  localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
  localparam logic [AW:0]         PTR_ONE = (AW + 1)'(1);
  localparam logic [POLARITY-1:0] POL_ON  = POLARITY'(1);
  localparam logic [POLARITY-1:0] POL_OFF = POLARITY'(2);

  // One buffered event. Polarity is reduced to a single ON bit once legality
  // has been established, so illegal codes never reach the FIFO.
  typedef struct packed {
`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0]  ts;
`endif
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             on;
  } entry_t;

  typedef enum logic {
    GRP_IDLE,
    GRP_COLLECT
  } grp_state_t;

  function automatic logic pol_legal(input logic [POLARITY-1:0] pol);
    return (pol == POL_ON) || (pol == POL_OFF);
  endfunction

  // Saturating increment by a single-bit amount.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             inc);
    return (inc && (cnt != CNT_MAX)) ? cnt + CNT_ONE : cnt;
  endfunction

  // ---------------------------------------------------------------------------
  // Input word decode
  // ---------------------------------------------------------------------------
  logic [ROW_W-1:0]    in_row;
  logic [COL_W-1:0]    in_col;
  logic [POLARITY-1:0] in_pol;
  logic                in_legal;
  entry_t              cap_entry;

  assign in_row   = data_i[WIDTH-1 -: ROW_W];
  assign in_col   = data_i[POLARITY +: COL_W];
  assign in_pol   = data_i[POLARITY-1:0];
  assign in_legal = evt_valid_i & pol_legal(in_pol);

`ifdef EVT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end
`endif

  // NOTE: every field gets a default before being overwritten so the
  // combinational block never holds a previous value and infers no latch.
  always_comb begin
    cap_entry     = '0;
    cap_entry.row = in_row;
    cap_entry.col = in_col;
    cap_entry.on  = (in_pol == POL_ON);
`ifdef EVT_TIMESTAMP_EN
    cap_entry.ts  = ts_cnt;
`endif
  end

  // ---------------------------------------------------------------------------
  // Capture stage: the word seen in cycle N is acted upon in cycle N+1.
  // ---------------------------------------------------------------------------
  logic   stg_valid;
  logic   stg_legal;
  entry_t stg_entry;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stg_valid <= 1'b0;
      stg_legal <= 1'b0;
      stg_entry <= '0;
    end else begin
      stg_valid <= evt_valid_i;
      stg_legal <= in_legal;
      if (evt_valid_i) begin
        stg_entry <= cap_entry;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO. Pointers carry one extra wrap bit: equal pointers mean empty,
  // pointers differing only in the wrap bit mean full.
  // ---------------------------------------------------------------------------
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [FIFO_DEPTH];
  entry_t      head_entry;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        push;
  logic        drop;
  logic        err_inc;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot being written when full, so the push is accepted.
  // There is no bypass: a push into an empty FIFO is not visible until the
  // next cycle, so it can never be popped in the cycle it is written.
  assign pop     = ~fifo_empty & evt_ready_i;
  assign push    = stg_valid & stg_legal & (~fifo_full | pop);
  assign drop    = stg_valid & stg_legal & fifo_full & ~pop;
  assign err_inc = stg_valid & ~stg_legal;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define which
  // entries are meaningful, and head outputs are forced to zero when empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= stg_entry;
    end
  end

  assign head_entry  = mem[rd_ptr[AW-1:0]];
  assign evt_valid_o = ~fifo_empty;
  assign row_o       = fifo_empty ? '0   : head_entry.row;
  assign col_o       = fifo_empty ? '0   : head_entry.col;
  assign pol_o       = fifo_empty ? 1'b0 : head_entry.on;
`ifdef EVT_TIMESTAMP_EN
  assign ts_o        = fifo_empty ? '0   : head_entry.ts;
`endif

  // ---------------------------------------------------------------------------
  // Error / drop statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err_cnt_o  <= '0;
      drop_cnt_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      err_cnt_o  <= sat_inc(err_cnt_o, err_inc);
      drop_cnt_o <= sat_inc(drop_cnt_o, drop);
      if (drop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Group tracking. Evaluated on the incoming word (capture time), so a legal
  // word arriving together with the release is counted into the closing group.
  // Legal words are counted whether or not the FIFO later accepts them.
  // ---------------------------------------------------------------------------
  grp_state_t       grp_state;
  logic [CNT_W-1:0] grp_cnt;

  assign grp_busy_o = (grp_state == GRP_COLLECT);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      grp_state  <= GRP_IDLE;
      grp_cnt    <= '0;
      grp_done_o <= 1'b0;
      grp_len_o  <= '0;
    end else begin
      grp_done_o <= 1'b0;
      unique case (grp_state)
        GRP_IDLE: begin
          if (grp_release_i && in_legal) begin
            // A one-word group that opens and closes in the same cycle.
            grp_len_o  <= sat_inc(grp_cnt, 1'b1);
            grp_done_o <= 1'b1;
          end else if (in_legal) begin
            grp_cnt   <= sat_inc(grp_cnt, 1'b1);
            grp_state <= GRP_COLLECT;
          end
        end
        GRP_COLLECT: begin
          if (grp_release_i) begin
            grp_len_o  <= sat_inc(grp_cnt, in_legal);
            grp_cnt    <= '0;
            grp_done_o <= 1'b1;
            grp_state  <= GRP_IDLE;
          end else begin
            grp_cnt <= sat_inc(grp_cnt, in_legal);
          end
        end
        default: begin
          grp_state <= GRP_IDLE;
          grp_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_packet_decoder.sv
// -----------------------------------------------------------------------------
// Testbench for event_packet_decoder (default parameters: 16x16, 2-bit
// polarity, 8-deep FIFO, 8-bit counters). Directed scenarios exercise the
// documented corner cases; a randomized run compares every output each cycle
// against a queue-based reference model of the decoder's observable behaviour.
// -----------------------------------------------------------------------------
module tb_event_packet_decoder;

  localparam int DEPTH = 8;
  localparam int CMAX  = 255;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  logic       evt_valid_i;
  logic [9:0] data_i;
  logic       grp_release_i;
  logic       evt_valid_o;
  logic       evt_ready_i;
  logic [3:0] row_o;
  logic [3:0] col_o;
  logic       pol_o;
  logic       grp_busy_o;
  logic       grp_done_o;
  logic [7:0] grp_len_o;
  logic [7:0] err_cnt_o;
  logic [7:0] drop_cnt_o;
  logic       overflow_o;
`ifdef EVT_TIMESTAMP_EN
  logic [15:0] ts_o;
`endif

  always #5 clk_i = ~clk_i;

  event_packet_decoder dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .evt_valid_i   (evt_valid_i),
    .data_i        (data_i),
    .grp_release_i (grp_release_i),
    .evt_valid_o   (evt_valid_o),
    .evt_ready_i   (evt_ready_i),
    .row_o         (row_o),
    .col_o         (col_o),
    .pol_o         (pol_o),
    .grp_busy_o    (grp_busy_o),
    .grp_done_o    (grp_done_o),
    .grp_len_o     (grp_len_o),
    .err_cnt_o     (err_cnt_o),
    .drop_cnt_o    (drop_cnt_o),
    .overflow_o    (overflow_o)
`ifdef EVT_TIMESTAMP_EN
    ,
    .ts_o          (ts_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: a queue of buffered events plus plain integer counters.
  // ---------------------------------------------------------------------------
  typedef struct {
    int row;
    int col;
    int pol;
    int ts;
  } ev_t;

  ev_t m_q[$];
  bit  m_stg_v;
  ev_t m_stg;
  int  m_err, m_drop, m_cnt, m_len, m_ts;
  bit  m_ovf, m_busy, m_done;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  function automatic bit legal(input int pol);
    return (pol == 1) || (pol == 2);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_stg_v = 0;
    m_stg   = '{0, 0, 0, 0};
    m_err = 0; m_drop = 0; m_cnt = 0; m_len = 0; m_ts = 0;
    m_ovf = 0; m_busy = 0; m_done = 0;
  endtask

  // One clock edge worth of behaviour, given this cycle's inputs.
  task automatic model_step(input bit v, input int row, input int col,
                            input int pol, input bit rel, input bit rdy);
    bit do_pop, stg_ok, do_push, in_ok;
    do_pop  = (m_q.size() > 0) && rdy;
    stg_ok  = m_stg_v && legal(m_stg.pol);
    do_push = stg_ok && ((m_q.size() < DEPTH) || do_pop);
    if (m_stg_v && !stg_ok) m_err = sat(m_err + 1);
    if (stg_ok && !do_push) begin
      m_drop = sat(m_drop + 1);
      m_ovf  = 1;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(m_stg);

    in_ok  = v && legal(pol);
    m_done = 0;
    if (rel && (m_busy || in_ok)) begin
      m_len  = sat(m_cnt + (in_ok ? 1 : 0));
      m_cnt  = 0;
      m_done = 1;
      m_busy = 0;
    end else if (in_ok) begin
      m_cnt  = sat(m_cnt + 1);
      m_busy = 1;
    end

    m_stg_v = v;
    if (v) m_stg = '{row, col, pol, m_ts};
    m_ts = (m_ts + 1) % 65536;
  endtask

  // Drive one cycle of inputs just after an edge, step the model, and return
  // 1 time unit after the next rising edge so outputs are settled.
  task automatic tick(input bit v, input int row, input int col, input int pol,
                      input bit rel, input bit rdy);
    evt_valid_i   = v;
    data_i        = {4'(row), 4'(col), 2'(pol)};
    grp_release_i = rel;
    evt_ready_i   = rdy;
    model_step(v, row, col, pol, rel, rdy);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) tick(0, 0, 0, 0, 0, rdy);
  endtask

  task automatic do_reset();
    reset_ni      = 1'b0;
    evt_valid_i   = 1'b0;
    data_i        = '0;
    grp_release_i = 1'b0;
    evt_ready_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    model_reset();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset_ni      = 1'b0;
    evt_valid_i   = 1'b0;
    data_i        = '0;
    grp_release_i = 1'b0;
    evt_ready_i   = 1'b0;
    #1;
    total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", evt_valid_o); end
    total++; if ({row_o, col_o, pol_o} !== 9'd0) begin bad++; $display("FAIL reset_head got=%h want=0", {row_o, col_o, pol_o}); end
    total++; if ({grp_busy_o, grp_done_o, grp_len_o} !== 10'd0) begin bad++; $display("FAIL reset_grp got=%h want=0", {grp_busy_o, grp_done_o, grp_len_o}); end
    total++; if ({err_cnt_o, drop_cnt_o, overflow_o} !== 17'd0) begin bad++; $display("FAIL reset_cnt got=%h want=0", {err_cnt_o, drop_cnt_o, overflow_o}); end
    repeat (2) @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    do_reset();
    idle(8, 0);
    tick(1, 3, 5, 1, 0, 0);  // word present in cycle N
    total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL single_n1_valid got=%b want=0", evt_valid_o); end
    idle(1, 0);              // now in cycle N+2
    total++; if (evt_valid_o !== 1'b1) begin bad++; $display("FAIL single_n2_valid got=%b want=1", evt_valid_o); end
    total++; if ({row_o, col_o, pol_o} !== {4'd3, 4'd5, 1'b1}) begin bad++; $display("FAIL single_head got=%0d/%0d/%0d want=3/5/1", row_o, col_o, pol_o); end
    idle(1, 0);
    total++; if ({evt_valid_o, row_o, col_o, pol_o} !== {1'b1, 4'd3, 4'd5, 1'b1}) begin bad++; $display("FAIL single_hold got=%h want=%h", {evt_valid_o, row_o, col_o, pol_o}, {1'b1, 4'd3, 4'd5, 1'b1}); end
    idle(1, 1);
    total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", evt_valid_o); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) tick(1, i, 15 - i, (i % 2) ? 2 : 1, 0, 0);
    idle(1, 0);
    total++; if (drop_cnt_o !== 8'd8) begin bad++; $display("FAIL ovf_drop got=%0d want=8", drop_cnt_o); end
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow_o); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({evt_valid_o, row_o, col_o, pol_o} !== {1'b1, 4'(i), 4'(15 - i), ((i % 2) == 0)}) begin
        bad++;
        $display("FAIL ovf_pop%0d got=v%b r%0d c%0d p%0d want=v1 r%0d c%0d p%0d",
                 i, evt_valid_o, row_o, col_o, pol_o, i, 15 - i, ((i % 2) == 0));
      end
      idle(1, 1);
    end
    total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", evt_valid_o); end
  endtask

  task automatic test_illegal();
    do_reset();
    tick(1, 1, 1, 0, 0, 1);
    tick(1, 2, 2, 3, 0, 1);
    idle(2, 1);
    total++; if (err_cnt_o !== 8'd2) begin bad++; $display("FAIL illegal_err got=%0d want=2", err_cnt_o); end
    total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL illegal_fifo got=%b want=0", evt_valid_o); end
    total++; if (grp_busy_o !== 1'b0) begin bad++; $display("FAIL illegal_busy got=%b want=0", grp_busy_o); end
  endtask

  task automatic test_group();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, i, i, 1, 0, 1);
    total++; if ({grp_busy_o, grp_done_o} !== 2'b10) begin bad++; $display("FAIL grp_collect got=%b want=10", {grp_busy_o, grp_done_o}); end
    tick(1, 5, 5, 2, 1, 1);  // release together with the 6th legal word
    total++; if (grp_done_o !== 1'b1) begin bad++; $display("FAIL grp_done got=%b want=1", grp_done_o); end
    total++; if (grp_len_o !== 8'd6) begin bad++; $display("FAIL grp_len got=%0d want=6", grp_len_o); end
    total++; if (grp_busy_o !== 1'b0) begin bad++; $display("FAIL grp_busy got=%b want=0", grp_busy_o); end
    idle(1, 1);
    total++; if ({grp_done_o, grp_len_o} !== {1'b0, 8'd6}) begin bad++; $display("FAIL grp_held got=%b/%0d want=0/6", grp_done_o, grp_len_o); end
    tick(0, 0, 0, 0, 1, 1);  // release while idle: ignored
    total++; if (grp_done_o !== 1'b0) begin bad++; $display("FAIL grp_idle_rel got=%b want=0", grp_done_o); end
    tick(1, 7, 7, 1, 1, 1);  // word + release while idle: one-word group
    total++; if ({grp_done_o, grp_len_o, grp_busy_o} !== {1'b1, 8'd1, 1'b0}) begin bad++; $display("FAIL grp_one got=%b/%0d/%b want=1/1/0", grp_done_o, grp_len_o, grp_busy_o); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 9; i++) tick(1, i, 0, 1, 0, 0);  // 8 buffered, 9th staged
    idle(1, 1);  // pop and push on the same edge
    total++; if (drop_cnt_o !== 8'd0) begin bad++; $display("FAIL fullpop_drop got=%0d want=0", drop_cnt_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL fullpop_ovf got=%b want=0", overflow_o); end
    for (int i = 1; i < 9; i++) begin
      total++;
      if ({evt_valid_o, row_o} !== {1'b1, 4'(i)}) begin
        bad++;
        $display("FAIL fullpop_entry%0d got=v%b r%0d want=v1 r%0d", i, evt_valid_o, row_o, i);
      end
      idle(1, 1);
    end
    total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL fullpop_empty got=%b want=0", evt_valid_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1, 9, 9, 3, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, i, i, 1, (i == 3), 0);
    idle(1, 0);
    total++; if ({evt_valid_o, err_cnt_o, grp_len_o} !== {1'b1, 8'd1, 8'd4}) begin bad++; $display("FAIL mid_before got=%b/%0d/%0d want=1/1/4", evt_valid_o, err_cnt_o, grp_len_o); end
    #2;
    reset_ni = 1'b0;
    #1;
    total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", evt_valid_o); end
    total++; if ({err_cnt_o, drop_cnt_o, grp_len_o, overflow_o} !== 25'd0) begin bad++; $display("FAIL mid_cnt got=%h want=0", {err_cnt_o, drop_cnt_o, grp_len_o, overflow_o}); end
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    model_reset();
    idle(2, 1);
    total++; if (evt_valid_o !== 1'b0) begin bad++; $display("FAIL mid_flushed got=%b want=0", evt_valid_o); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) tick(1, i % 16, i % 16, 3, 0, 0);
    for (int i = 0; i < 300; i++) tick(1, i % 16, i % 16, 2, 0, 0);
    idle(1, 0);
    total++; if (err_cnt_o !== 8'd255) begin bad++; $display("FAIL sat_err got=%0d want=255", err_cnt_o); end
    total++; if (drop_cnt_o !== 8'd255) begin bad++; $display("FAIL sat_drop got=%0d want=255", drop_cnt_o); end
    tick(0, 0, 0, 0, 1, 0);
    total++; if ({grp_done_o, grp_len_o} !== {1'b1, 8'd255}) begin bad++; $display("FAIL sat_len got=%b/%0d want=1/255", grp_done_o, grp_len_o); end
  endtask

  task automatic test_random();
    bit v, rel, rdy;
    int row, col, pol, sel, rdy_pct;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rdy_pct = ((cyc / 100) % 2 == 0) ? 20 : 85;
      v   = ($urandom_range(0, 99) < 70);
      row = $urandom_range(0, 15);
      col = $urandom_range(0, 15);
      sel = $urandom_range(0, 9);
      pol = (sel < 4) ? 1 : (sel < 8) ? 2 : (sel == 8) ? 0 : 3;
      rel = ($urandom_range(0, 99) < 8);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      tick(v, row, col, pol, rel, rdy);

      total++;
      if (evt_valid_o !== (m_q.size() > 0)) begin
        bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, evt_valid_o, (m_q.size() > 0));
      end else if (m_q.size() > 0) begin
        total++;
        if ({row_o, col_o, pol_o} !== {4'(m_q[0].row), 4'(m_q[0].col), (m_q[0].pol == 1)}) begin
          bad++; $display("FAIL rnd_head cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                          cyc, row_o, col_o, pol_o, m_q[0].row, m_q[0].col, (m_q[0].pol == 1));
        end
`ifdef EVT_TIMESTAMP_EN
        total++;
        if (ts_o !== 16'(m_q[0].ts)) begin
          bad++; $display("FAIL rnd_ts cyc=%0d got=%0d want=%0d", cyc, ts_o, m_q[0].ts);
        end
`endif
      end
      total++;
      if ({err_cnt_o, drop_cnt_o, overflow_o} !== {8'(m_err), 8'(m_drop), m_ovf}) begin
        bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d/%b want=%0d/%0d/%b",
                        cyc, err_cnt_o, drop_cnt_o, overflow_o, m_err, m_drop, m_ovf);
      end
      total++;
      if ({grp_busy_o, grp_done_o, grp_len_o} !== {m_busy, m_done, 8'(m_len)}) begin
        bad++; $display("FAIL rnd_grp cyc=%0d got=%b/%b/%0d want=%b/%b/%0d",
                        cyc, grp_busy_o, grp_done_o, grp_len_o, m_busy, m_done, m_len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_illegal();
    test_group();
    test_full_pop();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
